logic_result_checker: RTL and testbench

//  Downstream scoreboard for the 2-input gate bank (AND/OR/NAND/NOR/XOR/XNOR/NOT-a).

---
 rtl/logic_result_checker_if.sv | 26 ++
 rtl/logic_result_checker.sv | 155 +++++++++++++++
 tb/tb_logic_result_checker.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_result_checker_if.sv
// Sample channel into the gate-bank result checker.
// Ports: in_valid/a/b/res from the producer, in_ready back from the checker.
interface logic_result_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic       a;
    logic       b;
    // {a_not,c_xnor,c_xor,c_nor,c_nand,c_or,c_and}
    logic [6:0] res;

    modport master (
        output in_valid,
        output a,
        output b,
        output res,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  res,
        output in_ready
    );
endinterface

// File: rtl/logic_result_checker.sv
// Scoreboard for the 2-input gate bank: recomputes the seven gate outputs
// for each accepted sample, counts checks/mismatches and (a,b) coverage.
// Ports: clk, rst (async, active-high), start (run pulse), bus (sample
// channel, slave side), busy/done/pass verdict, chk_cnt/err_cnt/first_err
// counters, err_mask (sticky per-bit mismatch), cov (one bit per {a,b}).
module logic_result_checker #(
    parameter int CNT_W       = 16,
    parameter int NUM_CHECKS  = 4,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    logic_result_checker_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      chk_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [6:0]            err_mask,
    output logic [CNT_W-1:0]      first_err,
    output logic [3:0]            cov
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    // stage-1 capture of the accepted sample
    logic             s1_valid;
    logic             s1_a;
    logic             s1_b;
    logic [6:0]       s1_res;
    logic [CNT_W-1:0] s1_idx;

    logic [6:0]       expect_val;
    logic [6:0]       mism;
    logic             s2_err;
    logic             accept;
    logic             begin_run;
    logic             last_acc;
    logic             stop_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign bus.in_ready = (state == RUN);
    assign accept       = bus.in_valid & (state == RUN);
    assign begin_run    = start & ((state == IDLE) | (state == DONE));

    // Reference model of the gate bank for the captured operands.
    always_comb begin
        expect_val = {~s1_a,
                      ~(s1_a ^ s1_b),
                      s1_a ^ s1_b,
                      ~(s1_a | s1_b),
                      ~(s1_a & s1_b),
                      s1_a | s1_b,
                      s1_a & s1_b};
    end

    // Case inequality so an X/Z result bit is flagged, not silently passed.
    always_comb begin
        mism = '0;
        for (int i = 0; i < 7; i++) begin
            mism[i] = (s1_res[i] !== expect_val[i]);
        end
    end

    assign s2_err   = s1_valid & (|mism);
    assign last_acc = accept & (chk_cnt == LAST_IDX);
    // A sample accepted while the mismatch is being judged still gets checked
    // in DRAIN, but the run ends there.
    assign stop_hit = (STOP_ON_ERR != 0) & s2_err;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_acc | stop_hit) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage 1: capture. Invalid when no accept, so DRAIN empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= 1'b0;
            s1_b     <= 1'b0;
            s1_res   <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a   <= bus.a;
                s1_b   <= bus.b;
                s1_res <= bus.res;
                s1_idx <= chk_cnt;
            end
        end
    end

    // Run statistics. Stage-2 commits trail chk_cnt by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_cnt   <= '0;
            err_cnt   <= '0;
            err_mask  <= '0;
            first_err <= '0;
            cov       <= '0;
        end else if (begin_run) begin
            chk_cnt   <= '0;
            err_cnt   <= '0;
            err_mask  <= '0;
            first_err <= '0;
            cov       <= '0;
        end else begin
            if (accept) begin
                chk_cnt               <= sat_inc(chk_cnt);
                cov[{bus.a, bus.b}]   <= 1'b1;
            end
            if (s2_err) begin
                err_cnt  <= sat_inc(err_cnt);
                err_mask <= err_mask | mism;
                if (err_cnt == '0) begin
                    first_err <= s1_idx;
                end
            end
        end
    end

    assign busy = (state == RUN) | (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done & (err_cnt == '0) & (cov == 4'hF);

endmodule

// File: tb/tb_logic_result_checker.sv
// Directed bench for logic_result_checker: normal run, injected mismatch,
// partial coverage, stop-on-error, mid-run reset and an X result bit.
module tb_logic_result_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    always #5 clk = ~clk;

    logic_result_checker_if m0 ();
    logic_result_checker_if m1 ();

    logic        busy0, done0, pass0;
    logic [15:0] chk0, err0, ferr0;
    logic [6:0]  mask0;
    logic [3:0]  cov0;

    logic        busy1, done1, pass1;
    logic [15:0] chk1, err1, ferr1;
    logic [6:0]  mask1;
    logic [3:0]  cov1;

    logic_result_checker #(.CNT_W(16), .NUM_CHECKS(4), .STOP_ON_ERR(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .bus       (m0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .chk_cnt   (chk0),
        .err_cnt   (err0),
        .err_mask  (mask0),
        .first_err (ferr0),
        .cov       (cov0)
    );

    logic_result_checker #(.CNT_W(16), .NUM_CHECKS(4), .STOP_ON_ERR(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .bus       (m1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .chk_cnt   (chk1),
        .err_cnt   (err1),
        .err_mask  (mask1),
        .first_err (ferr1),
        .cov       (cov1)
    );

    // hand-computed gate-bank results {nota,xnor,xor,nor,nand,or,and}
    localparam logic [6:0] G00 = 7'b1101100;
    localparam logic [6:0] G10 = 7'b0010110;
    localparam logic [6:0] G01 = 7'b1010110;
    localparam logic [6:0] G11 = 7'b0100011;
    localparam logic [6:0] B11 = 7'b0110011; // xor bit flipped

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic send(input logic av, input logic bv, input logic [6:0] rv);
        int n;
        @(negedge clk);
        m0.a        = av;
        m0.b        = bv;
        m0.res      = rv;
        m0.in_valid = 1'b1;
        n = 0;
        while (!m0.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready", 32'(m0.in_ready), 1);
        @(posedge clk);
        #1 m0.in_valid = 1'b0;
    endtask

    task automatic wait_done0();
        int n;
        n = 0;
        while (!done0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done0", 32'(done0), 1);
    endtask

    initial begin
        logic [6:0] xr;
        int k;
        logic rdy;

        m0.in_valid = 1'b0; m0.a = 1'b0; m0.b = 1'b0; m0.res = '0;
        m1.in_valid = 1'b0; m1.a = 1'b0; m1.b = 1'b0; m1.res = '0;

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst busy", 32'(busy0), 0);
        check("rst done", 32'(done0), 0);
        check("rst ready", 32'(m0.in_ready), 0);
        check("rst chk", 32'(chk0), 0);
        check("rst cov", 32'(cov0), 0);

        // valid while idle: ignored
        m0.in_valid = 1'b1;
        @(negedge clk);
        check("idle valid", 32'(chk0), 0);
        m0.in_valid = 1'b0;

        // 1: full clean run
        pulse_start0();
        check("t1 busy", 32'(busy0), 1);
        send(1'b0, 1'b0, G00);
        send(1'b1, 1'b0, G10);
        send(1'b0, 1'b1, G01);
        send(1'b1, 1'b1, G11);
        wait_done0();
        check("t1 pass", 32'(pass0), 1);
        check("t1 chk", 32'(chk0), 4);
        check("t1 err", 32'(err0), 0);
        check("t1 cov", 32'(cov0), 32'hF);
        check("t1 busy", 32'(busy0), 0);

        // valid in DONE is ignored; start with valid wins
        m0.a = 1'b1; m0.b = 1'b1; m0.res = G11;
        m0.in_valid = 1'b1;
        @(negedge clk);
        check("done valid", 32'(chk0), 4);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        m0.in_valid = 1'b0;
        check("start wins chk", 32'(chk0), 0);
        check("start wins cov", 32'(cov0), 0);
        check("start wins busy", 32'(busy0), 1);

        // 2: xor bit flipped on (1,1) at index 1
        send(1'b0, 1'b0, G00);
        send(1'b1, 1'b1, B11);
        @(negedge clk);
        check("t2 lat chk", 32'(chk0), 2);
        check("t2 lat err", 32'(err0), 0);
        @(negedge clk);
        check("t2 err now", 32'(err0), 1);
        send(1'b1, 1'b0, G10);
        send(1'b0, 1'b1, G01);
        wait_done0();
        check("t2 err", 32'(err0), 1);
        check("t2 mask", 32'(mask0), 32'h10);
        check("t2 first", 32'(ferr0), 1);
        check("t2 pass", 32'(pass0), 0);
        check("t2 chk", 32'(chk0), 4);

        // 3: only (0,0) seen
        pulse_start0();
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, G00);
        wait_done0();
        check("t3 err", 32'(err0), 0);
        check("t3 cov", 32'(cov0), 1);
        check("t3 pass", 32'(pass0), 0);

        // 4: stop on error, valid held high
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && !done1; c++) begin
            if (k == 1) begin
                m1.a = 1'b1; m1.b = 1'b1; m1.res = B11;
            end else begin
                m1.a = 1'b0; m1.b = 1'b0; m1.res = G00;
            end
            m1.in_valid = 1'b1;
            rdy = m1.in_ready;
            @(posedge clk);
            if (rdy) k++;
            @(negedge clk);
        end
        m1.in_valid = 1'b0;
        check("t4 done", 32'(done1), 1);
        check("t4 chk", 32'(chk1), 3);
        check("t4 first", 32'(ferr1), 1);
        check("t4 err", 32'(err1), 1);
        check("t4 mask", 32'(mask1), 32'h10);

        // 5: reset mid-run, then clean run
        pulse_start0();
        send(1'b0, 1'b0, G00);
        send(1'b1, 1'b0, G10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5 chk", 32'(chk0), 0);
        check("t5 busy", 32'(busy0), 0);
        check("t5 ready", 32'(m0.in_ready), 0);
        check("t5 cov", 32'(cov0), 0);
        check("t5 done1", 32'(done1), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start0();
        send(1'b1, 1'b1, G11);
        send(1'b0, 1'b1, G01);
        send(1'b1, 1'b0, G10);
        send(1'b0, 1'b0, G00);
        wait_done0();
        check("t5 pass", 32'(pass0), 1);
        check("t5 chk2", 32'(chk0), 4);

        // 6: random valid gaps, X on res[0] for (1,1)
        xr = G11;
        xr[0] = 1'bx;
        pulse_start0();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(1'b0, 1'b0, G00);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(1'b0, 1'b1, G01);
        pulse_start0();
        check("t6 start ign", 32'(chk0), 2);
        check("t6 busy", 32'(busy0), 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(1'b1, 1'b0, G10);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(1'b1, 1'b1, xr);
        wait_done0();
        check("t6 err", 32'(err0), 1);
        check("t6 mask", 32'(mask0), 1);
        check("t6 first", 32'(ferr0), 3);
        check("t6 cov", 32'(cov0), 32'hF);
        check("t6 pass", 32'(pass0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
